mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the controller's strobe-based memory port
//  (address / to_mem / from_mem / mem_clock / mem_write).
//  - Holds a DEPTH x DATA_WIDTH RAM.
//  - Detects each rising edge of mem_clock, performs the read or write, then pulses mem_ready.
//  - Clears the RAM after reset; a streaming load port then fills the program image.
//  - Sits between ctrl and the testbench/boot source.
// PARAMETERS
//  ADDR_WIDTH      8                      address bits; also sets the load pointer width
//  DATA_WIDTH      8                      word width
//  DEPTH           1<<ADDR_WIDTH          number of words (derived; do not override)
//  CLEAR_ON_RESET  1                      1: zero all words after reset; 0: go straight to IDLE
// PORTS
//  clock       in   1           system clock; all logic on its rising edge
//  reset_n     in   1           synchronous reset, active-low
//  address     in   ADDR_WIDTH  access address from ctrl
//  to_mem      in   DATA_WIDTH  write data from ctrl
//  mem_write   in   1           1 = write, 0 = read; sampled on the strobe rise
//  mem_clock   in   1           access strobe from ctrl (level); each 0->1 edge is one request
//  from_mem    out  DATA_WIDTH  read data; held until the next completed read
//  mem_ready   out  1           one-cycle pulse when the request completes
//  load_valid  in   1           load-port word valid
//  load_data   in   DATA_WIDTH  load-port word
//  load_ready  out  1           load-port accept (valid & ready = one word written)
//  busy        out  1           1 while in CLEAR
//  err_overrun out  1           sticky: a strobe rise was dropped; cleared only by reset
// BEHAVIOUR
//  Reset (reset_n low at a clock edge):
//   - from_mem=0, mem_ready=0, load_ready=0, err_overrun=0.
//   - busy=CLEAR_ON_RESET, clr_ptr=0, load_ptr=0, strobe_q=0.
//   - state=CLEAR if CLEAR_ON_RESET, else IDLE.
//   - Reset mid-access abandons the access; a pending write is not performed.
//  Strobe detect: strobe_q<=mem_clock every cycle; rise = mem_clock & ~strobe_q.
//  FSM states: CLEAR, IDLE, ACCESS, ACK.
//   - CLEAR: mem[clr_ptr]<=0 and clr_ptr++ each cycle. After writing DEPTH-1 -> IDLE,
//     busy<=0. Takes exactly DEPTH cycles. A rise in CLEAR is dropped and sets err_overrun.
//   - IDLE: on rise, latch addr_q<=address, we_q<=mem_write, wd_q<=to_mem -> ACCESS.
//     Otherwise, if load_valid & load_ready: mem[load_ptr]<=load_data, load_ptr++.
//     load_ptr wraps from DEPTH-1 to 0.
//   - ACCESS: if we_q, mem[addr_q]<=wd_q and from_mem is unchanged;
//     else from_mem<=mem[addr_q]. Always -> ACK.
//   - ACK: mem_ready=1 for this one cycle -> IDLE.
//   - A rise in ACCESS or ACK is dropped and sets err_overrun.
//  Latency: rise seen at edge N; the RAM is updated or from_mem is valid after edge N+1;
//   mem_ready is high during the cycle after edge N+1 (it registers high at edge N+1
//   and falls at edge N+2). Back-to-back rises need at least 3 cycles spacing.
//  Load port:
//   - load_ready is registered; it is 1 only in IDLE when no rise is present this cycle.
//   - A strobe has priority over load: a simultaneous rise and load_valid gives
//     the strobe priority, and the load word stays pending (not consumed).
//  mem_write and address are don't-care except on the rise cycle.
//  mem_clock held high counts as one request.
//  Write then read of the same address returns the new data (ACCESS completes first).
// STRUCTURE
//  - Package mem_pkg: state enum (CLEAR, IDLE, ACCESS, ACK) and default width constants.
//  - One sub-module, strobe_edge: 1-flop rising-edge detector with sync reset,
//    output rise. RAM stays inline.
// TESTING
//  1. Reset, CLEAR_ON_RESET=1 -> busy=1 for exactly 256 cycles; every read then returns 0x00.
//  2. Load 0xC5,0xD8,0x41 with valid held -> mem[0..2]=C5,D8,41 and load_ptr=3;
//     a read of addr 1 gives from_mem=0xD8 and a single-cycle mem_ready.
//  3. Write 0x7E to addr 0xFF, then read 0xFF -> from_mem=0x7E;
//     from_mem is unchanged during the write.
//  4. Rise one cycle after an accepted rise -> second request ignored, err_overrun=1,
//     the first access still completes.
//  5. Rise and load_valid on the same cycle -> access served first;
//     the load word is written later at the same load_ptr.
//  6. reset_n low during ACCESS of a write to 0x10 -> mem[0x10]=0 after CLEAR;
//     all outputs are at their reset values.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default widths for the strobe-based memory responder.
package mem_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_e;

    // State entered out of reset: wipe the RAM first, or serve requests immediately.
    function automatic state_e reset_state(input bit clear_on_reset);
        return clear_on_reset ? ST_CLEAR : ST_IDLE;
    endfunction

endpackage

// File: rtl/mem_responder_strobe_edge.sv
// One-flop rising-edge detector for the controller's level access strobe.
module strobe_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic level,
    output logic rise
);

    logic strobe_q;

    // Remember last cycle's strobe level; cleared by reset so a high strobe
    // right after reset still counts as one request.
    always_ff @(posedge clock) begin
        if (!reset_n) strobe_q <= 1'b0;
        else          strobe_q <= level;
    end

    assign rise = level & ~strobe_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: RAM with strobe-triggered read/write, post-reset
// clear, and a streaming load port for the program image.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] to_mem,
    input  logic                  mem_write,
    input  logic                  mem_clock,
    output logic [DATA_WIDTH-1:0] from_mem,
    output logic                  mem_ready,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  busy,
    output logic                  err_overrun
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
    logic [ADDR_WIDTH-1:0] load_ptr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wd_q;
    logic [DATA_WIDTH-1:0] from_mem_q;
    logic                  ready_q;
    logic                  load_rdy_q;
    logic                  busy_q;
    logic                  err_q;

    logic                  rise;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_wa;
    logic [DATA_WIDTH-1:0] ram_wd;
    logic                  latch_req;
    logic                  load_fire;
    logic                  rd_en;
    logic                  set_err;

    strobe_edge u_strobe_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .level   (mem_clock),
        .rise    (rise)
    );

    // Next state plus the single RAM write port: clear, load and access
    // writes are mutually exclusive by state, and a strobe beats a load word.
    always_comb begin
        state_d   = state_q;
        ram_we    = 1'b0;
        ram_wa    = '0;
        ram_wd    = '0;
        latch_req = 1'b0;
        load_fire = 1'b0;
        rd_en     = 1'b0;
        set_err   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                ram_we  = 1'b1;
                ram_wa  = clr_ptr_q;
                set_err = rise;
                if (clr_ptr_q == {ADDR_WIDTH{1'b1}}) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise) begin
                    latch_req = 1'b1;
                    state_d   = ST_ACCESS;
                end else if (load_valid && load_rdy_q) begin
                    load_fire = 1'b1;
                    ram_we    = 1'b1;
                    ram_wa    = load_ptr_q;
                    ram_wd    = load_data;
                end
            end
            ST_ACCESS: begin
                set_err = rise;
                if (we_q) begin
                    ram_we = 1'b1;
                    ram_wa = addr_q;
                    ram_wd = wd_q;
                end else begin
                    rd_en = 1'b1;
                end
                state_d = ST_ACK;
            end
            ST_ACK: begin
                set_err = rise;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM array; gated by reset so an access interrupted by reset never lands.
    always_ff @(posedge clock) begin
        if (reset_n && ram_we) mem[ram_wa] <= ram_wd;
    end

    // Control registers, request latch, read data and registered status outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= reset_state(CLEAR_ON_RESET != 0);
            clr_ptr_q  <= '0;
            load_ptr_q <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wd_q       <= '0;
            from_mem_q <= '0;
            ready_q    <= 1'b0;
            load_rdy_q <= 1'b0;
            busy_q     <= (CLEAR_ON_RESET != 0);
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) clr_ptr_q <= clr_ptr_q + 1'b1;
            if (load_fire) load_ptr_q <= load_ptr_q + 1'b1;
            if (latch_req) begin
                addr_q <= address;
                we_q   <= mem_write;
                wd_q   <= to_mem;
            end
            if (rd_en) from_mem_q <= mem[addr_q];
            ready_q    <= (state_d == ST_ACK);
            load_rdy_q <= (state_d == ST_IDLE);
            busy_q     <= (state_d == ST_CLEAR);
            if (set_err) err_q <= 1'b1;
        end
    end

    assign from_mem    = from_mem_q;
    assign mem_ready   = ready_q;
    // Registered IDLE indication, withdrawn in a cycle where a strobe rise wins.
    assign load_ready  = load_rdy_q & ~rise;
    assign busy        = busy_q;
    assign err_overrun = err_q;

endmodule
